// File: rtl/soc_wb_pkg.sv
// Shared Wishbone arbiter types and constants for the on-chip SRAM path.
package soc_wb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   // Address is excluded because its width depends on the SRAM size.
   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
   } wb_req_t;

   localparam int unsigned WB_ARB_TIMEOUT_DEFAULT = 255;

   function automatic int unsigned cnt_width(input int unsigned t);
      int unsigned w;
      w = $clog2(t + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant selection; a tie goes to the master that was not served last.
module rr_arbiter_2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any_req,
   output logic next_grant
);

   always_comb begin
      any_req    = req0 | req1;
      next_grant = 1'b0;
      if (req0 && req1)
         next_grant = ~last_grant;
      else if (req1)
         next_grant = 1'b1;
   end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone classic arbiter in front of one SRAM wrapper slave.
// Optional bus-hang timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sram_arbiter
   import soc_wb_pkg::*;
#(
   parameter int unsigned ADDR_HI        = 14,
   parameter int unsigned TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_HI:2]  m0_adr_i,
   input  logic [3:0]        m0_sel_i,
   input  logic [31:0]       m0_dat_i,
   output logic [31:0]       m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_HI:2]  m1_adr_i,
   input  logic [3:0]        m1_sel_i,
   input  logic [31:0]       m1_dat_i,
   output logic [31:0]       m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_HI:2]  s_adr_o,
   output logic [3:0]        s_sel_o,
   output logic [31:0]       s_dat_o,
   input  logic [31:0]       s_dat_i,
   input  logic              s_ack_i
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_t        state;
   logic              grant;
   logic              last_grant;
   logic              busy;
   logic              req0, req1;
   logic              any_req, next_grant;
   logic              ack_fwd, tmo_hit;
   wb_req_t           m0_req, m1_req, sel_req;
   logic [ADDR_HI:2]  sel_adr;

   assign m0_req = '{m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_dat_i};
   assign m1_req = '{m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_dat_i};
   assign req0   = m0_cyc_i & m0_stb_i;
   assign req1   = m1_cyc_i & m1_stb_i;
   assign busy   = (state == ARB_BUSY);

   rr_arbiter_2 u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .any_req    (any_req),
      .next_grant (next_grant)
   );

   always_comb begin
      sel_req = grant ? m1_req : m0_req;
      sel_adr = grant ? m1_adr_i : m0_adr_i;
   end

   // Slave port mirrors the granted master only while BUSY; forced low in IDLE.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_sel_o = '0;
      s_dat_o = '0;
      if (busy) begin
         s_cyc_o = sel_req.cyc;
         s_stb_o = sel_req.stb;
         s_we_o  = sel_req.we;
         s_adr_o = sel_adr;
         s_sel_o = sel_req.sel;
         s_dat_o = sel_req.dat;
      end
   end

   // An ack after the granted master has dropped cyc belongs to an aborted cycle.
   assign ack_fwd = busy & sel_req.cyc & s_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
   logic [CW-1:0] tmo_cnt;

   assign tmo_hit = busy & sel_req.cyc & ~s_ack_i &
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         tmo_cnt <= '0;
      else if (!busy)
         tmo_cnt <= '0;
      else if (!s_ack_i)
         tmo_cnt <= tmo_cnt + CW'(1);
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign m0_ack_o = ack_fwd & ~grant;
   assign m1_ack_o = ack_fwd &  grant;
   assign m0_err_o = tmo_hit & ~grant;
   assign m1_err_o = tmo_hit &  grant;
   assign m0_dat_o = rst_i ? '0 : s_dat_i;
   assign m1_dat_o = rst_i ? '0 : s_dat_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ARB_IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (any_req) begin
                  grant      <= next_grant;
                  last_grant <= next_grant;
                  state      <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (s_ack_i || !sel_req.cyc || tmo_hit)
                  state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_sram_arbiter.md
# wb_sram_arbiter

Two-master Wishbone classic arbiter placed directly upstream of the on-chip SRAM wrapper slaves. The data port is master 0 and the instruction-fetch port is master 1. Both share one SRAM slave port, with round-robin arbitration, ack/data routing back to the granted master, and an optional bus-hang timeout. It drives one SRAM wrapper (32k or 8k) through its cyc/stb/adr/we/sel/dat handshake and consumes that wrapper's registered ack.

## Interface
Parameters:
- ADDR_HI, 14, MSB of the word address; the address bus is [ADDR_HI:2]. Use 14 for the 32k SRAM, 12 for the 8k SRAM.
- TIMEOUT_CYCLES, 255, number of BUSY cycles without ack before an error termination (used only with WB_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1  master 0 cycle, strobe, write enable.
- m0_adr_i  in  [ADDR_HI:2]  master 0 word address.
- m0_sel_i  in  4  master 0 byte selects.
- m0_dat_i  in  32  master 0 write data.
- m0_dat_o  out  32  master 0 read data.
- m0_ack_o, m0_err_o  out  1  master 0 normal termination, error termination.
- m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o: same directions and widths as the m0_* ports, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave cycle, strobe, write enable.
- s_adr_o  out  [ADDR_HI:2]  slave address.
- s_sel_o  out  4  slave byte selects.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.

## Operation
- The state machine has two states, IDLE and BUSY. Registers: state, grant (0/1), last_grant.
- IDLE: a master requests when cyc&stb is high.
  - Only one master requesting: grant that master.
  - Both requesting: grant the master that is not last_grant.
  - Any request: set last_grant to the new grant and go to BUSY.
  - No request: stay in IDLE.
  - All s_* outputs are 0 in IDLE.
- BUSY: the s_* outputs mirror the granted master's inputs combinationally. s_dat_i drives both m*_dat_o.
  - m{grant}_ack_o = s_ack_i. The non-granted master's ack_o and err_o are 0.
- BUSY exits to IDLE on any of:
  - s_ack_i (normal termination);
  - the granted master dropping cyc (abort; a late ack is not forwarded);
  - a timeout.
- Every transaction returns to IDLE for at least one cycle. This guarantees s_stb_o drops after ack, so the wrapper's ack toggle clears.
- Masters follow classic Wishbone: request signals are held stable until ack or err.
- A non-granted master waits with no ack; its request is not lost.
- Reset values: state=IDLE, grant=0, last_grant=1 (master 0 wins the first tie). All outputs are 0 during and after reset, including m*_dat_o, which is forced to 0 while rst_i is high.
- Reset asserted mid-transaction: the transaction is dropped, and no ack or err reaches either master.

## Timing
- Uncontended request at cycle N (IDLE):
  - s_stb_o is high in cycle N+1.
  - The wrapper acks in N+2, and m_ack_o is high in N+2 with valid dat_o.
  - The block is in IDLE in N+3.
- Back-to-back requests from the same master: one transaction every 3 cycles.
- Both masters requesting continuously: grants alternate 0,1,0,1, one 3-cycle transaction each.
- s_ack_i arriving in IDLE is ignored.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack, m{grant}_err_o pulses for one cycle, s_* drop in the next cycle, and the state goes to IDLE.
  - If ack and timeout occur in the same cycle, the ack wins.
- WB_ARB_TIMEOUT_EN undefined: there is no counter, m*_err_o are tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package soc_wb_pkg holds:
  - the typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  - a wb_req_t struct {cyc, stb, we, sel, dat} (address excluded, since its width is parameterized);
  - the constant WB_ARB_TIMEOUT_DEFAULT = 255.
- Sub-module rr_arbiter_2 computes the next grant from the two request bits and last_grant. It is purely combinational and is instantiated once.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle → all outputs 0 immediately. Then m0 reads addr 0x10 → s_stb_o high 1 cycle later, m0_ack_o high 2 cycles after the request, m0_dat_o = wrapper Q.
- Tie: m0 and m1 request in the same cycle after reset → m0 served first, then m1 (ack 3 cycles later). Both held continuously → strict alternation.
- Byte write: m1 writes 0xDEADBEEF to addr 0x20 with sel=4'b0100 → s_sel_o = 4'b0100, s_we_o = 1. Readback via m0 returns byte 2 = 0xAD.
- Abort: m0 drops cyc one cycle after the grant → the block returns to IDLE, m0_ack_o is never asserted, and a pending m1 request is granted next.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): s_ack_i held at 0 → m0_err_o pulses exactly once, on the 8th BUSY cycle, then IDLE. With the macro undefined: no err, stays in BUSY.
- Reset mid-BUSY: rst_i pulses in the cycle before the ack → no m*_ack_o, and the block is in IDLE with last_grant=1.
